vram_arbiter: RTL and testbench

- Shares one single-port, double-buffered pixel RAM between two requesters:
  - the display scanout, which issues one read per pixel tick and must never stall;
  - the GPU draw engine, which writes into the back buffer through a valid/ready handshake.
- Sequences page flips. A flip requested by the GPU is applied at the next vblank-start pulse from display timing.
- Sits between the VGA timing/colour path and the GPU raster unit. Runs on the 100 MHz system clock.

---
 rtl/vram_pkg.sv | 12 +
 rtl/vram_rd_pipe.sv | 27 ++
 rtl/vram_arbiter.sv | 101 ++++++++++
 tb/tb_vram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and defaults for the double-buffered VRAM arbiter.
package vram_pkg;
  localparam int AW_DEF     = 17;
  localparam int DW_DEF     = 12;
  localparam int RD_LAT_DEF = 2;
  localparam int PAGE_W     = 1;

  typedef enum logic {
    FLIP_IDLE    = 1'b0,
    FLIP_PENDING = 1'b1
  } flip_state_t;
endpackage

// File: rtl/vram_rd_pipe.sv
// Tracks issued scanout reads across the memory latency and registers returned data.
module vram_rd_pipe #(
  parameter int DW     = 12,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_issue,
  input  logic [DW-1:0] mem_rdata,
  output logic          sc_valid,
  output logic [DW-1:0] sc_data
);
  logic [RD_LAT-1:0] vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld      <= '0;
      sc_valid <= 1'b0;
      sc_data  <= '0;
    end else begin
      vld[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++) vld[i] <= vld[i-1];
      sc_valid <= vld[RD_LAT-1];
      if (vld[RD_LAT-1]) sc_data <= mem_rdata;
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Shares one single-port double-buffered pixel RAM between scanout reads (strict
// priority, never stalls) and draw writes, and applies page flips on vblank.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sc_req,
  input  logic [AW-1:0] sc_addr,
  output logic          sc_valid,
  output logic [DW-1:0] sc_data,
  input  logic          dr_valid,
  output logic          dr_ready,
  input  logic [AW-1:0] dr_addr,
  input  logic [DW-1:0] dr_data,
  input  logic          flip_req,
  input  logic          vblank_start,
  output logic          flip_busy,
  output logic          flip_done,
  output logic          front,
  output flip_state_t   flip_state,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  flip_state_t state;
  logic        dr_accept;

  // Draw handshake: a write transfers in any cycle where dr_valid && dr_ready.
  // dr_ready is combinational; scanout always wins and draw is held off while a
  // flip is pending so the page about to become visible is not touched.
  assign dr_ready   = !sc_req && (state == FLIP_IDLE);
  assign dr_accept  = dr_valid && dr_ready;
  assign flip_busy  = (state == FLIP_PENDING);
  assign flip_state = state;

  // The page bit is taken at grant time, so reads in flight across a flip
  // complete from the page they were issued against.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (sc_req) begin
      mem_en   <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= {front, sc_addr};
    end else if (dr_accept) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b1;
      mem_addr  <= {~front, dr_addr};
      mem_wdata <= dr_data;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
    end
  end

  // A flip request seen together with vblank_start waits for the next vblank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FLIP_IDLE;
      front     <= 1'b0;
      flip_done <= 1'b0;
    end else begin
      flip_done <= 1'b0;
      case (state)
        FLIP_IDLE: begin
          if (flip_req) state <= FLIP_PENDING;
        end
        FLIP_PENDING: begin
          if (vblank_start) begin
            state     <= FLIP_IDLE;
            front     <= ~front;
            flip_done <= 1'b1;
          end
        end
        default: state <= FLIP_IDLE;
      endcase
    end
  end

  vram_rd_pipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .rd_issue  (mem_en && !mem_we),
    .mem_rdata (mem_rdata),
    .sc_valid  (sc_valid),
    .sc_data   (sc_data)
  );
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, page-level reference model with a read
// return scoreboard, and directed plus random scenarios.
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW     = 17;
  localparam int DW     = 12;
  localparam int RD_LAT = 2;
  localparam int LAT    = RD_LAT + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sc_req, dr_valid, flip_req, vblank_start;
  logic [AW-1:0] sc_addr, dr_addr;
  logic [DW-1:0] dr_data;
  logic          sc_valid, dr_ready, flip_busy, flip_done, front;
  logic [DW-1:0] sc_data, mem_wdata, mem_rdata;
  logic          mem_en, mem_we;
  logic [AW:0]   mem_addr;
  flip_state_t   flip_state;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .sc_req(sc_req), .sc_addr(sc_addr), .sc_valid(sc_valid), .sc_data(sc_data),
    .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_addr(dr_addr), .dr_data(dr_data),
    .flip_req(flip_req), .vblank_start(vblank_start), .flip_busy(flip_busy),
    .flip_done(flip_done), .front(front), .flip_state(flip_state),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Unwritten pixels hold a page-dependent pattern; index 5 of page 0 is seeded.
  function automatic logic [DW-1:0] init_pix(input logic [AW:0] a);
    logic [DW-1:0] p;
    if (a == 18'h00005) return 12'hABC;
    p = a[DW-1:0] ^ (a[AW] ? 12'hF0F : 12'h000);
    return p;
  endfunction

  // Memory model: single port, read data RD_LAT cycles after the read strobe.
  logic [DW-1:0] ram [logic [AW:0]];
  logic [DW-1:0] rd_line [RD_LAT] = '{default: '0};

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    rd_line[0] <= (mem_en && !mem_we) ? (ram.exists(mem_addr) ? ram[mem_addr] : init_pix(mem_addr)) : '0;
    for (int i = 1; i < RD_LAT; i++) rd_line[i] <= rd_line[i-1];
  end
  assign mem_rdata = rd_line[RD_LAT-1];

  // Reference model: picture contents per page, flip sequencing, expected bus.
  logic [DW-1:0] shadow [logic [AW:0]];
  logic [DW-1:0] exp_q[$];
  int            due_q[$];
  logic          front_m, pend_m, done_m, en_m, we_m;
  logic [AW:0]   addr_m;
  logic [DW-1:0] wdata_m;
  int            cyc, total, bad;

  task automatic idle();
    sc_req = 0; sc_addr = '0; dr_valid = 0; dr_addr = '0; dr_data = '0;
    flip_req = 0; vblank_start = 0;
  endtask

  task automatic clear_model();
    exp_q.delete(); due_q.delete();
    front_m = 0; pend_m = 0; done_m = 0; en_m = 0; we_m = 0; addr_m = '0; wdata_m = '0;
  endtask

  // One cycle: scoreboard compare at negedge, then advance the model from the inputs.
  task automatic cycle();
    logic          exp_v, exp_rdy;
    logic [DW-1:0] exp_d;
    logic [AW:0]   a;
    @(negedge clk);
    exp_v = 0; exp_d = '0;
    if (due_q.size() != 0 && due_q[0] == cyc) begin
      exp_v = 1; exp_d = exp_q.pop_front(); void'(due_q.pop_front());
    end
    total++;
    if (sc_valid !== exp_v || (exp_v && sc_data !== exp_d)) begin
      bad++; $display("FAIL sc_return cyc=%0d got v=%b d=%h exp v=%b d=%h", cyc, sc_valid, sc_data, exp_v, exp_d);
    end
    exp_rdy = !sc_req && !pend_m;
    total++;
    if (dr_ready !== exp_rdy) begin
      bad++; $display("FAIL dr_ready cyc=%0d got %b exp %b", cyc, dr_ready, exp_rdy);
    end
    total++;
    if (mem_en !== en_m || mem_we !== we_m || mem_addr !== addr_m || mem_wdata !== wdata_m) begin
      bad++; $display("FAIL mem_bus cyc=%0d got en=%b we=%b a=%h d=%h exp en=%b we=%b a=%h d=%h",
                      cyc, mem_en, mem_we, mem_addr, mem_wdata, en_m, we_m, addr_m, wdata_m);
    end
    total++;
    if (front !== front_m || flip_busy !== pend_m || flip_done !== done_m ||
        flip_state !== (pend_m ? FLIP_PENDING : FLIP_IDLE)) begin
      bad++; $display("FAIL flip_state cyc=%0d got front=%b busy=%b done=%b exp front=%b busy=%b done=%b",
                      cyc, front, flip_busy, flip_done, front_m, pend_m, done_m);
    end
    done_m = 0;
    if (sc_req) begin
      a = {front_m, sc_addr};
      exp_q.push_back(shadow.exists(a) ? shadow[a] : init_pix(a));
      due_q.push_back(cyc + LAT);
      en_m = 1; we_m = 0; addr_m = a;
    end else if (dr_valid && exp_rdy) begin
      a = {~front_m, dr_addr};
      shadow[a] = dr_data;
      en_m = 1; we_m = 1; addr_m = a; wdata_m = dr_data;
    end else begin
      en_m = 0; we_m = 0;
    end
    if (!pend_m) pend_m = flip_req;
    else if (vblank_start) begin pend_m = 0; front_m = ~front_m; done_m = 1; end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    idle();
    repeat (LAT + 4) cycle();
  endtask

  task automatic release_reset();
    clear_model();
    repeat (2) @(posedge clk);
    #2 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    #7;
    total++;
    if (mem_en !== 0 || mem_we !== 0 || mem_addr !== '0 || mem_wdata !== '0 || sc_valid !== 0 ||
        sc_data !== '0 || front !== 0 || flip_busy !== 0 || flip_done !== 0) begin
      bad++; $display("FAIL reset_values got en=%b we=%b a=%h d=%h v=%b sd=%h f=%b b=%b dn=%b",
                      mem_en, mem_we, mem_addr, mem_wdata, sc_valid, sc_data, front, flip_busy, flip_done);
    end
    release_reset();
    cyc = 0;
    drain();
  endtask

  task automatic test_scan_latency();
    int lat;
    idle();
    sc_req = 1; sc_addr = 17'd5;
    cycle();
    idle();
    total++;
    if (mem_en !== 1 || mem_we !== 0 || mem_addr !== 18'h00005) begin
      bad++; $display("FAIL scan_issue got en=%b we=%b a=%h exp en=1 we=0 a=00005", mem_en, mem_we, mem_addr);
    end
    lat = 1;
    while (sc_valid !== 1'b1 && lat < 12) begin cycle(); lat++; end
    total++;
    if (lat != LAT || sc_data !== 12'hABC) begin
      bad++; $display("FAIL scan_latency got lat=%0d d=%h exp lat=%0d d=abc", lat, sc_data, LAT);
    end
    drain();
  endtask

  task automatic test_collision();
    idle();
    sc_req = 1; sc_addr = 17'd3; dr_valid = 1; dr_addr = 17'd7; dr_data = 12'h123;
    #1;
    total++;
    if (dr_ready !== 0) begin bad++; $display("FAIL collision_c0 got dr_ready=%b exp 0", dr_ready); end
    cycle();
    sc_req = 0;
    #1;
    total++;
    if (dr_ready !== 1) begin bad++; $display("FAIL collision_c1 got dr_ready=%b exp 1", dr_ready); end
    cycle();
    dr_valid = 0;
    total++;
    if (mem_en !== 1 || mem_we !== 1 || mem_addr !== {1'b1, 17'd7} || mem_wdata !== 12'h123) begin
      bad++; $display("FAIL collision_c2 got en=%b we=%b a=%h d=%h exp en=1 we=1 a=20007 d=123",
                      mem_en, mem_we, mem_addr, mem_wdata);
    end
    drain();
  endtask

  task automatic test_flip();
    idle();
    flip_req = 1; dr_valid = 1; dr_addr = 17'd9; dr_data = 12'h456;
    cycle();
    flip_req = 0;
    for (int c = 1; c < 10; c++) begin
      total++;
      if (flip_busy !== 1 || dr_ready !== 0) begin
        bad++; $display("FAIL flip_pending c=%0d got busy=%b rdy=%b exp busy=1 rdy=0", c, flip_busy, dr_ready);
      end
      cycle();
    end
    vblank_start = 1;
    cycle();
    vblank_start = 0;
    total++;
    if (front !== 1 || flip_done !== 1 || flip_busy !== 0) begin
      bad++; $display("FAIL flip_apply got front=%b done=%b busy=%b exp 1 1 0", front, flip_done, flip_busy);
    end
    cycle();
    dr_valid = 0; sc_req = 1; sc_addr = 17'd9;
    total++;
    if (flip_done !== 0 || mem_we !== 1 || mem_addr[AW] !== 1'b0) begin
      bad++; $display("FAIL flip_draw_page got done=%b we=%b page=%b exp done=0 we=1 page=0", flip_done, mem_we, mem_addr[AW]);
    end
    cycle();
    sc_req = 0;
    total++;
    if (mem_en !== 1 || mem_we !== 0 || mem_addr !== {1'b1, 17'd9}) begin
      bad++; $display("FAIL flip_scan_page got en=%b we=%b a=%h exp en=1 we=0 a=20009", mem_en, mem_we, mem_addr);
    end
    drain();
  endtask

  task automatic test_coincident();
    logic f0;
    idle();
    f0 = front_m;
    flip_req = 1; vblank_start = 1;
    cycle();
    idle();
    total++;
    if (flip_busy !== 1 || front !== f0 || flip_done !== 0) begin
      bad++; $display("FAIL coincident_first got busy=%b front=%b done=%b exp busy=1 front=%b done=0", flip_busy, front, flip_done, f0);
    end
    repeat (4) cycle();
    vblank_start = 1;
    cycle();
    vblank_start = 0;
    total++;
    if (front !== ~f0 || flip_done !== 1) begin
      bad++; $display("FAIL coincident_second got front=%b done=%b exp front=%b done=1", front, flip_done, ~f0);
    end
    drain();
  endtask

  task automatic test_throughput();
    int acc, rets;
    acc = 0; rets = 0;
    for (int i = 0; i < 300; i++) begin
      sc_req = (i % 4 == 0); sc_addr = 17'($urandom_range(0, 76799));
      dr_valid = 1; dr_addr = 17'($urandom_range(0, 76799)); dr_data = 12'($urandom);
      #1;
      if (dr_valid && dr_ready) acc++;
      cycle();
      if (sc_valid) rets++;
    end
    idle();
    repeat (LAT + 2) begin cycle(); if (sc_valid) rets++; end
    total++;
    if (acc != 225) begin bad++; $display("FAIL throughput_writes got %0d exp 225", acc); end
    total++;
    if (rets != 75) begin bad++; $display("FAIL throughput_reads got %0d exp 75", rets); end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      sc_req = ($urandom_range(0, 3) == 0); sc_addr = 17'($urandom_range(0, 31));
      dr_valid = $urandom_range(0, 1); dr_addr = 17'($urandom_range(0, 31)); dr_data = 12'($urandom);
      flip_req = ($urandom_range(0, 49) == 0); vblank_start = ($urandom_range(0, 29) == 0);
      cycle();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int seen;
    idle();
    sc_req = 1; sc_addr = 17'd2; flip_req = 1;
    cycle();
    sc_addr = 17'd3; flip_req = 0;
    cycle();
    idle();
    #2 rst = 1;
    #1;
    total++;
    if (mem_en !== 0 || mem_we !== 0 || mem_addr !== '0 || mem_wdata !== '0 || sc_valid !== 0 ||
        sc_data !== '0 || front !== 0 || flip_busy !== 0 || flip_done !== 0) begin
      bad++; $display("FAIL reset_mid got en=%b we=%b a=%h d=%h v=%b sd=%h f=%b b=%b dn=%b",
                      mem_en, mem_we, mem_addr, mem_wdata, sc_valid, sc_data, front, flip_busy, flip_done);
    end
    release_reset();
    seen = 0;
    repeat (LAT + 4) begin cycle(); if (sc_valid) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL reset_mid_returns got %0d exp 0", seen); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    clear_model();
    test_reset();
    test_scan_latency();
    test_collision();
    test_flip();
    test_coincident();
    test_throughput();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
